ccc_lock_reset_sequencer: RTL
=============================

Name: ccc_lock_reset_sequencer

Overview:
- Sits directly downstream of the fabric CCC. It is clocked by the CCC global output GL0 and consumes the CCC LOCK output.
- Synchronises and filters LOCK, then releases a staged pair of active-high reset outputs:
  - system fabric reset first;
  - peripheral/subsystem reset a fixed gap later.
- Re-asserts both resets on loss of lock and counts lock-loss events for housekeeping telemetry.

Parameters:
SYNC_STAGES, 2, depth of the pll_lock synchroniser flop chain (legal: >=2)
LOCK_FILTER_CYCLES, 1024, consecutive cycles of synchronised lock required before sys_rst is released (legal: >=1)
STAGE_GAP_CYCLES, 16, cycles between sys_rst release and periph_rst release (legal: >=1)

Ports:
- clk  in  1  GL0 from CCC; the only clock
- rst  in  1  synchronous, active-high reset
- pll_lock  in  1  CCC LOCK; asynchronous to clk; synchronised internally
- soft_rst_req  in  1  synchronous, level-sensitive software reset request
- clr_sticky  in  1  synchronous; clears lock_lost when high
- sys_rst  out  1  active-high fabric system reset
- periph_rst  out  1  active-high peripheral reset
- ready  out  1  high only in RUN
- lock_lost  out  1  sticky flag, set on any lock loss after release
- lock_loss_count  out  8  saturating count of lock-loss events
- state_dbg  out  3  encoded FSM state: WAIT_LOCK=0, FILTER=1, RELEASE_SYS=2, RUN=3

Behaviour:
- Interface clocking and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - On rst: sync chain=0, FSM=WAIT_LOCK, counters=0, sys_rst=1, periph_rst=1, ready=0, lock_lost=0, lock_loss_count=0.
  - rst mid-operation behaves identically, including when applied in RUN.
- Outputs: all registered; no combinational path from any input to any output.
- Synchroniser: lock_s = last flop of the SYNC_STAGES chain. Only lock_s is used internally.
- WAIT_LOCK:
  - cnt=0; sys_rst=1, periph_rst=1.
  - lock_s=1 -> FILTER with cnt=0.
- FILTER:
  - lock_s=0 -> WAIT_LOCK. No loss counted, because the block was never released.
  - soft_rst_req=1 -> cnt restarts at 0.
  - Otherwise cnt+1 each cycle.
  - At cnt==LOCK_FILTER_CYCLES-1 with lock_s=1 -> RELEASE_SYS; sys_rst=0 on that edge; cnt=0.
- Release timing from lock:
  - Condition: pll_lock held high from edge E, starting in WAIT_LOCK.
  - sys_rst falls at edge E+SYNC_STAGES+LOCK_FILTER_CYCLES.
- RELEASE_SYS:
  - cnt counts to STAGE_GAP_CYCLES-1, then -> RUN.
  - periph_rst=0 and ready=1 on the same edge as entry to RUN.
  - periph_rst falls exactly STAGE_GAP_CYCLES edges after sys_rst fell.
- Lock loss (lock_s=0 in RELEASE_SYS or RUN):
  - Next edge -> WAIT_LOCK.
  - sys_rst=1, periph_rst=1, ready=0 on that same edge.
  - lock_lost=1; lock_loss_count+1, saturating at 255.
- soft_rst_req=1 in RELEASE_SYS or RUN with lock_s=1:
  - Next edge -> FILTER with cnt=0.
  - Both resets=1, ready=0.
  - No loss counted, lock_lost unchanged.
- Priorities:
  - rst > lock loss > soft_rst_req.
  - Set of lock_lost beats clr_sticky in the same cycle.
  - clr_sticky does not affect lock_loss_count, which clears only on rst.
- Invariants:
  - periph_rst=0 implies sys_rst=0.
  - ready == (state==RUN).
  - Resets are never released while lock_s=0.
- Counter width: ceil(log2(max(LOCK_FILTER_CYCLES, STAGE_GAP_CYCLES))), minimum 1 bit. cnt never wraps.

Test Plan:
- Nominal release (SYNC_STAGES=2, LOCK_FILTER_CYCLES=8, STAGE_GAP_CYCLES=4):
  - Stimulus: rst for 3 cycles, then pll_lock high from edge E.
  - Required: sys_rst falls at E+10; periph_rst and ready change at E+14; state_dbg=3.
- Glitchy lock during filter:
  - Stimulus: pll_lock high 5 cycles, low 1 cycle, then high.
  - Required: filter restarts; sys_rst stays 1 until 10 edges after the final rise; lock_loss_count=0; lock_lost=0.
- Lock loss in RUN:
  - Stimulus: drop pll_lock.
  - Required: 3 edges later, sys_rst=periph_rst=1, ready=0, lock_lost=1, lock_loss_count=1.
  - Then restore lock: full re-release sequence with the same timing as scenario 1.
- Saturation and sticky:
  - Stimulus: 260 lock-loss events.
  - Required: lock_loss_count=255.
  - clr_sticky asserted alone -> lock_lost=0, count still 255.
  - clr_sticky coincident with a loss edge -> lock_lost=1.
- Soft reset:
  - Stimulus: soft_rst_req pulse of 1 cycle in RUN.
  - Required: resets reassert next edge; sys_rst falls 8 edges later; periph_rst 4 after that; lock_loss_count unchanged.
- Reset mid-release:
  - Stimulus: assert rst while in RELEASE_SYS.
  - Required: next edge all outputs at reset values, state_dbg=0; sequence resumes correctly after rst deasserts.

Source files
------------

// File: rtl/ccc_lock_reset_sequencer.sv
// Purpose: synchronise/filter CCC LOCK and release sys_rst then periph_rst; latency SYNC_STAGES+LOCK_FILTER_CYCLES to sys_rst release.
// Backpressure: none; free-running sequencer, lock loss or soft reset re-asserts both resets on the next edge.
module ccc_lock_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_FILTER_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    input  logic       clr_sticky,
    output logic       sys_rst,
    output logic       periph_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state_dbg
);

    localparam int MAX_CYCLES = (LOCK_FILTER_CYCLES > STAGE_GAP_CYCLES) ?
                                LOCK_FILTER_CYCLES : STAGE_GAP_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        FILTER      = 3'd1,
        RELEASE_SYS = 3'd2,
        RUN         = 3'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   loss;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        loss      = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) begin
                    state_nxt = FILTER;
                end
            end
            FILTER: begin
                // Dropping out of FILTER is not a loss: nothing was ever released.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (soft_rst_req) begin
                    cnt_nxt = '0;
                end else if (cnt == FILT_LAST) begin
                    state_nxt = RELEASE_SYS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RELEASE_SYS: begin
                if (!lock_s) begin
                    loss      = 1'b1;
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (soft_rst_req) begin
                    state_nxt = FILTER;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    loss      = 1'b1;
                    state_nxt = WAIT_LOCK;
                end else if (soft_rst_req) begin
                    state_nxt = FILTER;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            sys_rst         <= 1'b1;
            periph_rst      <= 1'b1;
            ready           <= 1'b0;
            lock_lost       <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sys_rst    <= !((state_nxt == RELEASE_SYS) || (state_nxt == RUN));
            periph_rst <= (state_nxt != RUN);
            ready      <= (state_nxt == RUN);
            if (loss) begin
                lock_lost <= 1'b1;
            end else if (clr_sticky) begin
                lock_lost <= 1'b0;
            end
            if (loss && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

    assign state_dbg = state;

endmodule
